// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int unsigned CNT_W = 4;

  // Data returned for an out-of-range fetch; truncated to the bus width at use.
  localparam logic [63:0] ERR_DATA = '0;

endpackage

// File: rtl/imem_array.sv
// Word storage: synchronous write port, asynchronous read port, contents not reset.
module imem_array #(
  parameter int unsigned BITSIZE = 32,
  parameter int unsigned DEPTH   = 1024,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [BITSIZE-1:0] wdata,
  input  logic [IDX_W-1:0]   raddr,
  output logic [BITSIZE-1:0] rdata_c
);

  logic [BITSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read sees the pre-edge contents, so a same-cycle write is not forwarded.
  assign rdata_c = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder for the core fetch port: answers word reads after LATENCY cycles
// from an internal array that is filled through a separate load port.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned BITSIZE   = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic [BITSIZE-1:0] MEM_addr_i,
  input  logic               MEM_read_i,
  output logic [BITSIZE-1:0] MEM_data_o,
  output logic               MEM_valid_o,
  output logic               err_o,
  input  logic               ld_we_i,
  input  logic [BITSIZE-1:0] ld_addr_i,
  input  logic [BITSIZE-1:0] ld_data_i
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]   CNT_LOAD    = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [BITSIZE-1:0] BASE        = BITSIZE'(BASE_ADDR);
  localparam logic [BITSIZE-1:0] DEPTH_WORDS = BITSIZE'(DEPTH);

  function automatic logic in_range(input logic [BITSIZE-1:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < DEPTH_WORDS);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [BITSIZE-1:0] a);
    return IDX_W'((a - BASE) >> 2);
  endfunction

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [BITSIZE-1:0] cap_addr, cap_addr_d;
  logic [BITSIZE-1:0] data_d;
  logic               valid_d, err_d;
  logic [BITSIZE-1:0] rd_addr_c;
  logic [BITSIZE-1:0] rdata_c;
  logic               rd_ok_c;

  // With LATENCY=1 the read happens while still in IDLE, before the address is captured.
  assign rd_addr_c = (state == IDLE) ? MEM_addr_i : cap_addr;
  assign rd_ok_c   = in_range(rd_addr_c);

  imem_array #(
    .BITSIZE(BITSIZE),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk    (clk),
    .we     (ld_we_i && in_range(ld_addr_i)),
    .waddr  (word_idx(ld_addr_i)),
    .wdata  (ld_data_i),
    .raddr  (word_idx(rd_addr_c)),
    .rdata_c(rdata_c)
  );

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state       <= IDLE;
      cnt         <= '0;
      cap_addr    <= '0;
      MEM_valid_o <= 1'b0;
      err_o       <= 1'b0;
      MEM_data_o  <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      cap_addr    <= cap_addr_d;
      MEM_valid_o <= valid_d;
      err_o       <= err_d;
      MEM_data_o  <= data_d;
    end
  end

  // Next state, wait counter and next registered outputs.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    cap_addr_d = cap_addr;
    unique case (state)
      IDLE: begin
        if (MEM_read_i) begin
          cap_addr_d = MEM_addr_i;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!MEM_read_i)    state_d = IDLE;
        else if (cnt == '0) state_d = RESP;
        else                cnt_d   = cnt - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == RESP);
    err_d   = valid_d && !rd_ok_c;
    data_d  = MEM_data_o;
    if (valid_d) data_d = rd_ok_c ? rdata_c : BITSIZE'(ERR_DATA);
  end

endmodule
